// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_pkg
// Description : Phase encoding and lamp decode shared by the traffic-light block.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_GREEN = 3'd0,
        PH_BOFF  = 3'd1,
        PH_BGRN  = 3'd2,
        PH_YEL   = 3'd3,
        PH_RED   = 3'd4,
        PH_FLASH = 3'd5
    } phase_e;

    // Returns {R,G,Y}; FLASH gives its "on" half, the FSM toggles Y itself.
    function automatic logic [2:0] lamp_of(input phase_e ph);
        logic [2:0] rgy;
        rgy = 3'b000;
        case (ph)
            PH_GREEN, PH_BGRN: rgy = 3'b010;
            PH_YEL, PH_FLASH:  rgy = 3'b001;
            PH_RED:            rgy = 3'b100;
            default:           rgy = 3'b000;
        endcase
        return rgy;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_if
// Description : Request inputs and lamp/phase outputs of one approach.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_if;
    import traffic_light_pkg::*;

    logic               pass;
    logic               night;
    logic               R;
    logic               G;
    logic               Y;
    logic [PHASE_W-1:0] phase;

    modport master (output pass, output night, input R, input G, input Y, input phase);
    modport slave  (input pass, input night, output R, output G, output Y, output phase);

endinterface
`default_nettype wire

// File: rtl/tl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tl_phase_timer
// Description : Phase duration counter; o_done flags the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_phase_timer #(
    parameter int CNT_W = 9
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           i_clr,
    input  wire logic [CNT_W:0] i_len,
    output logic                o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_last;

    assign w_last = i_len - 1'b1;
    assign o_done = ({1'b0, r_cnt} == w_last);

    // Holding at the terminal count keeps the counter from ever wrapping.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (!o_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Parametrised single-approach light sequencer with pass request;
//               night flashing-yellow mode enabled by TL_NIGHT_MODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int CNT_W    = 9,
    parameter int T_GREEN  = 512,
    parameter int T_BLINK  = 64,
    parameter int BLINK_N  = 2,
    parameter int T_YELLOW = 256,
    parameter int T_RED    = 512
) (
    input wire logic        clk,
    input wire logic        rst,
    traffic_light_if.slave  bus
);

    localparam int IDX_W = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;
    localparam logic [CNT_W:0] c_LEN_GREEN  = (CNT_W+1)'(T_GREEN);
    localparam logic [CNT_W:0] c_LEN_BLINK  = (CNT_W+1)'(T_BLINK);
    localparam logic [CNT_W:0] c_LEN_YELLOW = (CNT_W+1)'(T_YELLOW);
    localparam logic [CNT_W:0] c_LEN_RED    = (CNT_W+1)'(T_RED);

    if (T_GREEN < 1 || T_GREEN > (1 << CNT_W) || T_BLINK < 1 || T_BLINK > (1 << CNT_W) ||
        T_YELLOW < 1 || T_YELLOW > (1 << CNT_W) || T_RED < 1 || T_RED > (1 << CNT_W) ||
        BLINK_N < 0) begin : g_param_err
        $error("traffic_light_ctrl: duration out of 1..2**CNT_W or negative BLINK_N");
    end

    phase_e           r_phase;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_rgy;
    logic [CNT_W:0]   w_len;
    logic             w_done;
    logic             w_clr;
    logic             w_night_req;
    logic             w_in_flash;
    logic             w_pass_take;

`ifdef TL_NIGHT_MODE_EN
    assign w_night_req = bus.night;
`else
    assign w_night_req = 1'b0 & bus.night;
`endif

    assign w_in_flash  = (r_phase == PH_FLASH);
    assign w_pass_take = bus.pass && (r_phase != PH_GREEN) && !w_in_flash;
    // Any night entry/exit, accepted pass or expiry restarts the phase timer.
    assign w_clr       = w_done || (w_night_req != w_in_flash) || w_pass_take;

    always_comb begin
        w_len = c_LEN_GREEN;
        case (r_phase)
            PH_BOFF, PH_BGRN, PH_FLASH: w_len = c_LEN_BLINK;
            PH_YEL:                     w_len = c_LEN_YELLOW;
            PH_RED:                     w_len = c_LEN_RED;
            default:                    w_len = c_LEN_GREEN;
        endcase
    end

    tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_len  (w_len),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_GREEN;
            r_idx   <= '0;
            r_rgy   <= lamp_of(PH_GREEN);
        end else if (w_night_req && !w_in_flash) begin
            r_phase <= PH_FLASH;
            r_idx   <= '0;
            r_rgy   <= lamp_of(PH_FLASH);
        end else if (w_in_flash) begin
            if (!w_night_req) begin
                r_phase <= PH_RED;
                r_rgy   <= lamp_of(PH_RED);
            end else if (w_done) begin
                r_rgy   <= {2'b00, ~r_rgy[0]};
            end
        end else if (w_pass_take) begin
            r_phase <= PH_GREEN;
            r_idx   <= '0;
            r_rgy   <= lamp_of(PH_GREEN);
        end else if (w_done) begin
            case (r_phase)
                PH_GREEN: begin
                    if (BLINK_N > 0) begin
                        r_phase <= PH_BOFF;
                        r_rgy   <= lamp_of(PH_BOFF);
                    end else begin
                        r_phase <= PH_YEL;
                        r_rgy   <= lamp_of(PH_YEL);
                    end
                end
                PH_BOFF: begin
                    r_phase <= PH_BGRN;
                    r_rgy   <= lamp_of(PH_BGRN);
                end
                PH_BGRN: begin
                    if (int'(r_idx) < BLINK_N - 1) begin
                        r_phase <= PH_BOFF;
                        r_idx   <= r_idx + 1'b1;
                        r_rgy   <= lamp_of(PH_BOFF);
                    end else begin
                        r_phase <= PH_YEL;
                        r_idx   <= '0;
                        r_rgy   <= lamp_of(PH_YEL);
                    end
                end
                PH_YEL: begin
                    r_phase <= PH_RED;
                    r_rgy   <= lamp_of(PH_RED);
                end
                default: begin
                    r_phase <= PH_GREEN;
                    r_idx   <= '0;
                    r_rgy   <= lamp_of(PH_GREEN);
                end
            endcase
        end
    end

    assign bus.phase = r_phase;
    assign bus.R     = r_rgy[2];
    assign bus.G     = r_rgy[1];
    assign bus.Y     = r_rgy[0];

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Scoreboard bench for a default and a short-timing instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;
    import traffic_light_pkg::*;

    typedef struct {
        int ph;
        int len;
    } seg_t;

`ifdef TL_NIGHT_MODE_EN
    localparam bit c_NIGHT = 1'b1;
`else
    localparam bit c_NIGHT = 1'b0;
`endif
    localparam int c_TB_A = 64;
    localparam int c_TB_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_light_if ifa ();
    traffic_light_if ifb ();

    traffic_light_ctrl dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    traffic_light_ctrl #(
        .CNT_W(3), .T_GREEN(4), .T_BLINK(2), .BLINK_N(0), .T_YELLOW(3), .T_RED(5)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    seg_t       sa[$];
    seg_t       sb[$];
    logic [5:0] qa[$];
    logic [5:0] qb[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  pa = 0, ea = 0, pb = 0, eb = 0;
    bit  fla = 0, fya = 0, flb = 0, fyb = 0;

    // The sequence as a list of (phase, duration) segments; RED is always last.
    function automatic void step(input seg_t s[$], input int tb, input logic r, p, n,
                                 inout int pos, inout int el, inout bit fl, inout bit fy);
        if (r) begin
            pos = 0; el = 0; fl = 0; fy = 0;
            return;
        end
        if (c_NIGHT && n && !fl) begin
            fl = 1; el = 0; fy = 1;
            return;
        end
        if (fl) begin
            if (!n) begin
                fl = 0; pos = s.size() - 1; el = 0;
            end else if (el == tb - 1) begin
                el = 0; fy = !fy;
            end else begin
                el++;
            end
            return;
        end
        if (p && s[pos].ph != 0) begin
            pos = 0; el = 0;
            return;
        end
        if (el == s[pos].len - 1) begin
            pos = (pos + 1) % s.size(); el = 0;
        end else begin
            el++;
        end
    endfunction

    function automatic logic [5:0] exp_of(input int ph, input bit fy);
        logic [5:0] v;
        case (ph)
            0:       v = {3'd0, 3'b010};
            1:       v = {3'd1, 3'b000};
            2:       v = {3'd2, 3'b010};
            3:       v = {3'd3, 3'b001};
            4:       v = {3'd4, 3'b100};
            default: v = {3'd5, 2'b00, fy};
        endcase
        return v;
    endfunction

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t: got phase=%0d RGY=%b, expected phase=%0d RGY=%b",
                      nm, $time, act[5:3], act[2:0], exp[5:3], exp[2:0]);
    endtask

    task automatic cyc(input logic r, input logic p, input logic n);
        @(posedge clk);
        #2;
        rst = r;
        ifa.pass = p;  ifb.pass = p;
        ifa.night = n; ifb.night = n;
    endtask

    initial begin
        ifa.pass = 1'b0; ifb.pass = 1'b0;
        ifa.night = 1'b0; ifb.night = 1'b0;
        sa.push_back('{0, 512});
        for (int i = 0; i < 2; i++) begin
            sa.push_back('{1, 64});
            sa.push_back('{2, 64});
        end
        sa.push_back('{3, 256});
        sa.push_back('{4, 512});
        sb.push_back('{0, 4});
        sb.push_back('{3, 3});
        sb.push_back('{4, 5});
    end

    // Reference model: samples the inputs seen at each edge and queues the expected outputs.
    initial forever begin
        @(posedge clk);
        step(sa, c_TB_A, rst, ifa.pass, ifa.night, pa, ea, fla, fya);
        qa.push_back(exp_of(fla ? 5 : sa[pa].ph, fya));
        step(sb, c_TB_B, rst, ifb.pass, ifb.night, pb, eb, flb, fyb);
        qb.push_back(exp_of(flb ? 5 : sb[pb].ph, fyb));
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (qa.size() == 0) begin
            n_chk++;
            $display("FAIL sb_a_empty t=%0t: got no expected entry, required one", $time);
        end else begin
            chk("inst_a", {ifa.phase, ifa.R, ifa.G, ifa.Y}, qa.pop_front());
        end
        if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_b_empty t=%0t: got no expected entry, required one", $time);
        end else begin
            chk("inst_b", {ifb.phase, ifb.R, ifb.G, ifb.Y}, qb.pop_front());
        end
    end

    initial begin
        int hold;
        logic nt;
        hold = 0;
        nt = 1'b0;
        // free run, then a one-cycle pass during yellow
        cyc(1, 0, 0);
        repeat (900) cyc(0, 0, 0);
        cyc(0, 1, 0);
        repeat (1400) cyc(0, 0, 0);
        // pass held from inside the long green
        repeat (2) cyc(1, 0, 0);
        repeat (100) cyc(0, 0, 0);
        repeat (600) cyc(0, 1, 0);
        repeat (1100) cyc(0, 0, 0);
        // single-cycle reset in the middle of red
        repeat (2) cyc(1, 0, 0);
        repeat (1200) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (1600) cyc(0, 0, 0);
        // random pass / night / occasional reset
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                nt   = ($urandom_range(0, 3) == 0);
                hold = $urandom_range(50, 400);
            end
            hold--;
            cyc(($urandom_range(0, 1999) == 0), ($urandom_range(0, 299) == 0), nt);
        end
        repeat (3) cyc(0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
